// File: rtl/inv_round_engine_pkg.sv
// rtl/inv_round_engine_pkg.sv - shared FSM type and GF(2^8) helpers for the inverse round engine
package inv_round_engine_pkg;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  localparam logic [8:0] GF_POLY = 9'h11b;
  localparam logic [3:0] IMC_C0 = 4'he;
  localparam logic [3:0] IMC_C1 = 4'hb;
  localparam logic [3:0] IMC_C2 = 4'hd;
  localparam logic [3:0] IMC_C3 = 4'h9;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

  // Coefficients are at most 4 bits wide, so three xtime steps cover them all.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] acc;
    p   = b;
    acc = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (c[k]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*r+8*c +: 8] = gf_mul_const(s[32*r+8*c +: 8], IMC_C0)
                         ^ gf_mul_const(s[32*((r+1)%4)+8*c +: 8], IMC_C1)
                         ^ gf_mul_const(s[32*((r+2)%4)+8*c +: 8], IMC_C2)
                         ^ gf_mul_const(s[32*((r+3)%4)+8*c +: 8], IMC_C3);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[103:96], s[127:104], s[79:64], s[95:80], s[55:32], s[63:56], s[31:0]};
  endfunction

endpackage

// File: rtl/inv_round_engine_inv_sbox.sv
// rtl/inv_round_engine_inv_sbox.sv - combinational FIPS-197 inverse S-box
module inv_sbox
  import inv_round_engine_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] result
);

  // Entry 0x00 sits in the top byte; ~data turns the byte value into a slice offset.
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign result = TABLE[{~data, 3'b000} +: 8];

endmodule

// File: rtl/inv_round_engine.sv
// rtl/inv_round_engine.sv - one AES inverse round, one InvSubBytes byte per cycle
module inv_round_engine
  import inv_round_engine_pkg::*;
#(
  parameter int NB_ROWS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [32*NB_ROWS-1:0]   state_in,
  input  logic [32*NB_ROWS-1:0]   round_key,
  input  logic                    last_round,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NB_ROWS-1:0]   state_out
);

  state_t         state;
  logic [3:0]     cnt;
  logic [127:0]   data;
  logic [127:0]   key;
  logic           last;
  logic [7:0]     sbox_in;
  logic [7:0]     sbox_out;
  logic [127:0]   keyed;
  logic [127:0]   mixed;

  assign in_ready = (state == IDLE);
  assign sbox_in  = data[{cnt, 3'b000} +: 8];
  assign keyed    = data ^ key;
  assign mixed    = last ? keyed : inv_mix_cols(keyed);

  inv_sbox u_inv_sbox (
    .data   (sbox_in),
    .result (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data      <= '0;
      key       <= '0;
      last      <= 1'b0;
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data  <= inv_shift_rows(state_in);
          key   <= round_key;
          last  <= last_round;
          cnt   <= 4'd0;
          state <= SUB;
        end
        SUB: begin
          data[{cnt, 3'b000} +: 8] <= sbox_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= MIX;
        end
        MIX: begin
          state_out <= mixed;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_round_engine.sv
// tb/tb_inv_round_engine.sv - randomized scoreboard bench for inv_round_engine
module tb_inv_round_engine;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] round_key = '0;
  logic         last_round = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [127:0] state_out;

  inv_round_engine #(.NB_ROWS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .round_key(round_key), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           e;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         hold_bp = 1;
  logic [7:0]   fwd_tbl[256];
  logic [7:0]   inv_tbl[256];

  function automatic void chk(string nm, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endfunction

  // Reference GF(2^8) arithmetic: schoolbook product then polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv, base;
    int e;
    inv = 8'h00;
    if (x != 0) begin
      inv = 8'h01; base = x; e = 254;
      while (e > 0) begin
        if (e % 2 == 1) inv = gmul(inv, base);
        base = gmul(base, base);
        e = e / 2;
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic l);
    logic [7:0]   a[4][4];
    logic [127:0] o;
    logic [7:0]   coef[4];
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = inv_tbl[s[32*r + 8*((c - r) & 3) +: 8]] ^ k[32*r + 8*c +: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (l) o[32*r + 8*c +: 8] = a[r][c];
        else
          for (int j = 0; j < 4; j++)
            o[32*r + 8*c +: 8] = o[32*r + 8*c +: 8] ^ gmul(coef[(j - r) & 3], a[j][c]);
      end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: samples just after each edge; out_ready seen now is the value that edge used.
  logic         prev_ov = 0;
  logic [127:0] prev_out = '0;
  always @(posedge clk) begin
    exp_t x;
    #1;
    cyc++;
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          x = exp_q.pop_front();
          chk("state_out", state_out, x.d);
          chk("latency", 128'(cyc - x.e), 128'd17);
        end
      end else if (prev_ov) begin
        if (!out_ready) begin
          chk("hold_valid", 128'(out_valid), 128'd1);
          chk("hold_data", state_out, prev_out);
        end else begin
          chk("release_valid", 128'(out_valid), 128'd0);
          chk("release_ready", 128'(in_ready), 128'd1);
        end
      end
    end
    prev_ov  = out_valid;
    prev_out = state_out;
  end

  initial begin
    forever begin
      @(negedge clk);
      out_ready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l, input logic [127:0] want);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
    in_valid = 1; state_in = s; round_key = k; last_round = l;
    x.d = want; x.e = cyc + 1;
    exp_q.push_back(x);
    @(negedge clk);
    in_valid = 0;
    state_in = rand128(); round_key = rand128(); last_round = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [127:0] s, k, e, q, so;
    logic         l;
    logic [7:0]   col0[4];
    int           n;
    for (int i = 0; i < 256; i++) fwd_tbl[i] = fwd_sbox(8'(i));
    for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);

    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_state_out", state_out, 128'd0);
    hold_bp = 0;

    send('0, '0, 1, {16{8'h52}});
    send({16{8'h63}}, '0, 1, '0);
    send({16{8'h63}}, {16{8'hff}}, 1, {16{8'hff}});

    col0[0] = 8'h8e; col0[1] = 8'h4d; col0[2] = 8'ha1; col0[3] = 8'hbc;
    q = '0; s = '0; e = {16{8'h52}};
    for (int r = 0; r < 4; r++) q[32*r +: 8] = fwd_tbl[col0[r]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[32*r + 8*c +: 8] = q[32*r + 8*((c + r) & 3) +: 8];
    e[7:0] = 8'hdb; e[39:32] = 8'h13; e[71:64] = 8'h53; e[103:96] = 8'h45;
    send(s, '0, 0, e);

    send({32'h63636363, 32'h63636363, 32'h7b777c4b, 32'h63636363}, '0, 1,
         {32'h0, 32'h0, 32'h0201cc03, 32'h0});

    for (int t = 0; t < 20; t++) begin
      s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
      send(s, k, l, ref_round(s, k, l));
    end
    drain();

    hold_bp = 1;
    s = rand128(); k = rand128();
    send(s, k, 0, ref_round(s, k, 0));
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", 128'(out_valid), 128'd1);
    so = state_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", state_out, so);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      in_valid = (i % 2 == 0 && i < 9);
      state_in = rand128(); round_key = rand128();
    end
    in_valid = 0;
    hold_bp = 0;
    drain();

    s = rand128(); k = rand128();
    send(s, k, 0, ref_round(s, k, 0));
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_state_out", state_out, 128'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    s = rand128(); k = rand128();
    send(s, k, 1, ref_round(s, k, 1));
    s = rand128(); k = rand128();
    send(s, k, 0, ref_round(s, k, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
